spi_reg_bridge: RTL and testbench

Byte-level command decoder that sits directly downstream of the SPI slave. It consumes received bytes (spi_data_out/spi_data_stb) and the transaction-start pulse, and turns them into single-cycle register-bus read/write operations with auto-incrementing address. It also supplies the next transmit byte (spi_data_in) back to the SPI slave for read transactions.

---
 rtl/spi_reg_bridge.sv | 96 +++++++++
 tb/tb_spi_reg_bridge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// Byte-level command decoder between an SPI slave and a simple register bus.
// Byte 0 is the command: bit7 selects write or read, and the low bits give the start address.
// The following bytes are data (write) or dummies (read) at an auto-incrementing address.
module spi_reg_bridge #(
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        spi_data_out,
  input  logic              spi_data_stb,
  input  logic              spi_tsx_start,
  output logic [7:0]        spi_data_in,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [7:0]        bus_rdata,
  output logic              busy
);

  // state    | meaning
  // IDLE     | after reset, waiting for the first transaction start
  // CMD      | waiting for the command byte
  // WR_DATA  | each received byte is written at bus_addr
  // RD_ISSUE | issue bus_re at bus_addr
  // RD_WAIT  | wait for read data, then load it into the transmit byte
  // RD_DATA  | transmit byte ready; the next dummy byte triggers a prefetch
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CMD      = 3'd1;
  localparam logic [2:0] WR_DATA  = 3'd2;
  localparam logic [2:0] RD_ISSUE = 3'd3;
  localparam logic [2:0] RD_WAIT  = 3'd4;
  localparam logic [2:0] RD_DATA  = 3'd5;

  logic [2:0] state;
  logic [1:0] lat_cnt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= 2'd0;
      spi_data_in <= 8'h00;
      bus_addr    <= '0;
      bus_wdata   <= 8'h00;
      bus_we      <= 1'b0;
      bus_re      <= 1'b0;
    end else begin
      bus_we <= 1'b0;
      bus_re <= 1'b0;
      if (bus_we) bus_addr <= bus_addr + ADDR_W'(1);
      if (spi_tsx_start) begin
        // a new transaction wins over a coincident byte and drops any read in flight
        state       <= CMD;
        spi_data_in <= 8'h00;
      end else begin
        case (state)
          CMD: begin
            if (spi_data_stb) begin
              bus_addr <= spi_data_out[ADDR_W-1:0];
              state    <= spi_data_out[7] ? WR_DATA : RD_ISSUE;
            end
          end
          WR_DATA: begin
            if (spi_data_stb) begin
              bus_wdata <= spi_data_out;
              bus_we    <= 1'b1;
            end
          end
          RD_ISSUE: begin
            bus_re  <= 1'b1;
            lat_cnt <= 2'(RD_LAT);
            state   <= RD_WAIT;
          end
          RD_WAIT: begin
            // bus_rdata is sampled RD_LAT cycles after the cycle in which bus_re is high
            if (lat_cnt == 2'd0) begin
              spi_data_in <= bus_rdata;
              bus_addr    <= bus_addr + ADDR_W'(1);
              state       <= RD_DATA;
            end else begin
              lat_cnt <= lat_cnt - 2'd1;
            end
          end
          RD_DATA: begin
            if (spi_data_stb) state <= RD_ISSUE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: stimulus pushes the expected bus accesses,
// and a negedge monitor pops and compares each bus_we or bus_re it observes.
module tb_spi_reg_bridge;

  typedef struct {
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
  } bus_ev_t;

  logic       clk;
  logic       rst;
  logic [7:0] spi_data_out;
  logic       spi_data_stb;
  logic       spi_tsx_start;
  logic [7:0] spi_data_in;
  logic [6:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  bus_ev_t exp_q[$];

  localparam int GAP = 6;

  spi_reg_bridge #(.ADDR_W(7), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .spi_data_out(spi_data_out), .spi_data_stb(spi_data_stb), .spi_tsx_start(spi_tsx_start),
    .spi_data_in(spi_data_in),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register model with one cycle of read latency, returning addr ^ 8'hC0.
  always @(posedge clk) begin
    if (bus_re) bus_rdata <= {1'b0, bus_addr} ^ 8'hC0;
  end

  always @(negedge clk) begin
    bus_ev_t e;
    if (!rst && (bus_we || bus_re)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_bus we=%0b re=%0b addr=%h wdata=%h (none expected)",
                 bus_we, bus_re, bus_addr, bus_wdata);
      end else begin
        e = exp_q.pop_front();
        if ((bus_we && bus_re) || e.we !== bus_we || e.addr !== bus_addr ||
            (e.we && e.wdata !== bus_wdata)) begin
          n_fail++;
          $display("FAIL bus_access got we=%0b re=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                   bus_we, bus_re, bus_addr, bus_wdata, e.we, e.addr, e.wdata);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [6:0] addr, input logic [7:0] wdata);
    bus_ev_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  task automatic pulse_byte(input logic [7:0] b);
    @(posedge clk); #1;
    spi_data_out = b;
    spi_data_stb = 1'b1;
    @(posedge clk); #1;
    spi_data_stb = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pulse_byte(b);
    repeat (GAP) @(posedge clk);
  endtask

  task automatic tsx_start();
    @(posedge clk); #1;
    spi_tsx_start = 1'b1;
    @(posedge clk); #1;
    spi_tsx_start = 1'b0;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_spi_data_in"}, 32'(spi_data_in), 32'h0);
    check({name, "_bus_addr"},    32'(bus_addr),    32'h0);
    check({name, "_bus_wdata"},   32'(bus_wdata),   32'h0);
    check({name, "_bus_we_re"},   32'({bus_we, bus_re}), 32'h0);
    check({name, "_busy"},        32'(busy),        32'h0);
  endtask

  initial begin
    rst = 1'b1;
    spi_data_out = 8'h00;
    spi_data_stb = 1'b0;
    spi_tsx_start = 1'b0;
    bus_rdata = 8'h00;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Bytes before any transaction start are ignored.
    send_byte(8'h85); send_byte(8'h11); send_byte(8'h22);
    check("prestart_busy", 32'(busy), 32'h0);
    check("prestart_miso", 32'(spi_data_in), 32'h0);

    // Write burst at 5, 6, 7.
    tsx_start();
    check("wr_busy", 32'(busy), 32'h1);
    send_byte(8'h85);
    push(1'b1, 7'h05, 8'h11); send_byte(8'h11);
    push(1'b1, 7'h06, 8'h22); send_byte(8'h22);
    push(1'b1, 7'h07, 8'h33); send_byte(8'h33);
    check("wr_pending", 32'(exp_q.size()), 32'h0);
    check("wr_miso", 32'(spi_data_in), 32'h0);

    // Reset asserted while a write strobe is high clears everything asynchronously.
    tsx_start();
    send_byte(8'h83);
    push(1'b1, 7'h03, 8'h44);
    pulse_byte(8'h44);
    #5;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #3;
    rst = 1'b0;
    send_byte(8'h91); send_byte(8'h12); send_byte(8'h13);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pending", 32'(exp_q.size()), 32'h0);

    // Read burst from 10h: D0..D3 appear RD_LAT+2 clocks after each stb.
    tsx_start();
    for (int k = 0; k < 4; k++) begin
      logic [7:0] prev;
      prev = (k == 0) ? 8'h00 : 8'hD0 + 8'(k - 1);
      check($sformatf("rd_miso_slot%0d", k), 32'(spi_data_in), 32'(prev));
      push(1'b0, 7'h10 + 7'(k), 8'h00);
      pulse_byte((k == 0) ? 8'h10 : 8'h00);
      repeat (2) @(posedge clk); #1;
      check($sformatf("rd_hold%0d", k), 32'(spi_data_in), 32'(prev));
      @(posedge clk); #1;
      check($sformatf("rd_data%0d", k), 32'(spi_data_in), 32'(8'hD0 + 8'(k)));
      repeat (GAP) @(posedge clk);
    end
    check("rd_pending", 32'(exp_q.size()), 32'h0);

    // Address wraps from 7Fh to 00h.
    tsx_start();
    send_byte(8'hFF);
    push(1'b1, 7'h7F, 8'h01); send_byte(8'h01);
    push(1'b1, 7'h00, 8'h02); send_byte(8'h02);
    check("wrap_pending", 32'(exp_q.size()), 32'h0);

    // Abort a read: transaction start coincides with the first dummy byte.
    tsx_start();
    push(1'b0, 7'h05, 8'h00);
    send_byte(8'h05);
    check("abort_rd_data", 32'(spi_data_in), 32'hC5);
    @(posedge clk); #1;
    spi_tsx_start = 1'b1;
    spi_data_stb = 1'b1;
    spi_data_out = 8'h00;
    @(posedge clk); #1;
    spi_tsx_start = 1'b0;
    spi_data_stb = 1'b0;
    check("abort_miso_clear", 32'(spi_data_in), 32'h0);
    repeat (GAP) @(posedge clk);
    send_byte(8'h83);
    push(1'b1, 7'h03, 8'hAA); send_byte(8'hAA);
    check("abort_pending", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
